// File: rtl/fpga_top_mul_share_arb_if.sv
// Request/response bundle between the lane engines and the shared multiplier.
// The requesters use the master modport; the multiplier block uses the slave modport.
interface fpga_top_mul_share_arb_if #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 9,
  parameter int B_WIDTH  = 10,
  parameter int P_WIDTH  = 16,
  parameter int ID_WIDTH = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ-1:0]         rsp_ready;
  logic [P_WIDTH-1:0]         rsp_p;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic                       busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id, busy
  );
endinterface

// File: rtl/fpga_top_mul_share_arb.sv
// Round-robin sharing of one multiplier among NUM_REQ requesters, one-cycle registered result.
// Optional counters grant_cnt/stall_cnt are enabled by FPGA_TOP_MUL_SHARE_ARB_STATS_EN.
module fpga_top_mul_share_arb #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 9,
  parameter int B_WIDTH  = 10,
  parameter int P_WIDTH  = 16,
  parameter int ID_WIDTH = 2
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
`ifdef FPGA_TOP_MUL_SHARE_ARB_STATS_EN
  output logic [31:0] grant_cnt,
  output logic [31:0] stall_cnt,
`endif
  fpga_top_mul_share_arb_if.slave bus
);
  localparam int FULL_WIDTH = A_WIDTH + B_WIDTH;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]            state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   rsp_id_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [P_WIDTH-1:0]    rsp_p_q;

  logic                  found;
  logic [ID_WIDTH-1:0]   grant;
  logic                  can_accept;
  logic                  consume;
  logic                  transfer;
  logic [NUM_REQ-1:0]    ready_vec;
  logic [A_WIDTH-1:0]    a_sel;
  logic [B_WIDTH-1:0]    b_sel;
  logic [FULL_WIDTH-1:0] full_prod;

  assign consume    = (state == ST_FULL) && bus.rsp_ready[rsp_id_q];
  assign can_accept = (state == ST_EMPTY) || consume;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = idx[ID_WIDTH-1:0];
      end
    end
  end

  assign transfer = found && can_accept && ap_rst_n;

  always_comb begin
    ready_vec = '0;
    if (transfer) ready_vec[grant] = 1'b1;
  end

  assign a_sel     = bus.req_a[grant*A_WIDTH +: A_WIDTH];
  assign b_sel     = bus.req_b[grant*B_WIDTH +: B_WIDTH];
  assign full_prod = FULL_WIDTH'(a_sel) * FULL_WIDTH'(b_sel);

  // A concurrent consume and accept keeps the register FULL for one result per cycle.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state       <= ST_EMPTY;
      rr_ptr      <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
    end else if (transfer) begin
      state       <= ST_FULL;
      rsp_id_q    <= grant;
      rsp_p_q     <= full_prod[P_WIDTH-1:0];
      rsp_valid_q <= NUM_REQ'(1) << grant;
      rr_ptr      <= (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end else if (consume) begin
      state       <= ST_EMPTY;
      rsp_valid_q <= '0;
    end
  end

`ifdef FPGA_TOP_MUL_SHARE_ARB_STATS_EN
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (transfer && grant_cnt != 32'hFFFF_FFFF) grant_cnt <= grant_cnt + 32'd1;
      if ((state == ST_FULL) && !bus.rsp_ready[rsp_id_q] && (|bus.req_valid)
          && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state == ST_FULL);
endmodule
